fpu_exp_normalizer: RTL and testbench

FPU_EXP_NORMALIZER -- requirements
Module: fpu_exp_normalizer

---
 rtl/fpu_exp_normalizer.sv | 150 +++++++++++++++
 tb/tb_fpu_exp_normalizer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_exp_normalizer.sv
// Exponent/mantissa normalizer with round-to-nearest-even, producing an IEEE-754 single.
// Define FPU_NORM_FAST_SHIFT_EN to normalize in one cycle via a leading-zero count.
module fpu_exp_normalizer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_sign,
    input  logic [7:0]  i_exp,
    input  logic [26:0] i_mant,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_inexact,
    output logic        o_overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t      state, state_next;
    logic        sign_q;
    logic [7:0]  exp_q;
    logic [26:0] mant_q;
    logic        shift_stop;

    logic        round_up;
    logic [24:0] sum;
    logic [8:0]  exp_r;
    logic [22:0] frac;
    logic [31:0] res_result;
    logic        res_inexact;
    logic        res_overflow;

    // exp 255 (inf/NaN) bypasses normalization entirely
    assign shift_stop = (exp_q == 8'hFF) || mant_q[26] || (mant_q == '0) || (exp_q <= 8'd1);

`ifdef FPU_NORM_FAST_SHIFT_EN
    logic [4:0] lz;
    logic [7:0] shamt;

    function automatic logic [4:0] lead_zeros(input logic [26:0] m);
        logic [4:0] n;
        logic       found;
        n     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (!found && !m[26-i]) n = n + 5'd1;
            else found = 1'b1;
        end
        return n;
    endfunction

    // shift count clamped so the exponent never drops below 1
    always_comb begin
        lz    = lead_zeros(mant_q);
        shamt = ({3'b000, lz} > (exp_q - 8'd1)) ? (exp_q - 8'd1) : {3'b000, lz};
        if (shift_stop) shamt = '0;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (i_valid) state_next = SHIFT;
`ifdef FPU_NORM_FAST_SHIFT_EN
            SHIFT: state_next = ROUND;
`else
            SHIFT: if (shift_stop) state_next = ROUND;
`endif
            ROUND: state_next = DONE;
            DONE:  if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    always_comb begin
        round_up     = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        sum          = {1'b0, mant_q[26:3]} + {24'b0, round_up};
        frac         = sum[22:0];
        res_inexact  = |mant_q[2:0];
        res_overflow = 1'b0;
        if (sum[24]) begin
            exp_r = {1'b0, exp_q} + 9'd1;
            frac  = '0;
        end else if (mant_q[26]) begin
            exp_r = {1'b0, exp_q};
        end else if (sum[23]) begin
            exp_r = 9'd1;
        end else begin
            exp_r = '0;
        end
        res_result = {sign_q, exp_r[7:0], frac};
        if (exp_r >= 9'd255) begin
            res_result   = {sign_q, 8'hFF, 23'b0};
            res_overflow = 1'b1;
        end
        if (exp_q == 8'hFF) begin
            res_result   = {sign_q, 8'hFF, mant_q[25:3]};
            res_inexact  = 1'b0;
            res_overflow = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            o_result   <= '0;
            o_inexact  <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        sign_q <= i_sign;
                        exp_q  <= i_exp;
                        mant_q <= i_mant;
                    end
                end
                SHIFT: begin
`ifdef FPU_NORM_FAST_SHIFT_EN
                    mant_q <= mant_q << shamt;
                    exp_q  <= exp_q - shamt;
`else
                    if (!shift_stop) begin
                        mant_q <= {mant_q[25:0], 1'b0};
                        exp_q  <= exp_q - 8'd1;
                    end
`endif
                end
                ROUND: begin
                    o_result   <= res_result;
                    o_inexact  <= res_inexact;
                    o_overflow <= res_overflow;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_exp_normalizer.sv
// Self-checking bench for fpu_exp_normalizer: vector table with scoreboard, plus hold and reset sequences.
// Honours FPU_NORM_FAST_SHIFT_EN for expected latency.
module tb_fpu_exp_normalizer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_sign = 1'b0;
    logic [7:0]  i_exp = '0;
    logic [26:0] i_mant = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_inexact;
    logic        o_overflow;

    fpu_exp_normalizer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sign(i_sign), .i_exp(i_exp), .i_mant(i_mant), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_inexact(o_inexact),
        .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [26:0] mant;
        logic [31:0] result;
        logic        inexact;
        logic        overflow;
        int unsigned nshift;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic        inexact;
        logic        overflow;
        int unsigned latency;
    } exp_t;

    localparam int unsigned NVEC = 15;
    vec_t vecs [NVEC];
    exp_t sb [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic int unsigned lat_of(input int unsigned n);
`ifdef FPU_NORM_FAST_SHIFT_EN
        return 2;
`else
        return n + 2;
`endif
    endfunction

    // returns one time unit after the accepting edge
    task automatic send(input logic s, input logic [7:0] e, input logic [26:0] m);
        int unsigned guard = 0;
        @(negedge i_clk);
        while (!o_ready && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_ready) check("ready_timeout", 32'd0, 32'd1);
        i_sign  = s;
        i_exp   = e;
        i_mant  = m;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic await_result(output int unsigned k);
        k = 0;
        while (!o_valid && k < 100) begin
            @(posedge i_clk);
            #1;
            k++;
        end
        if (!o_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_output(input string tag, input int unsigned k);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_result"},   o_result, e.result);
        check({tag, "_inexact"},  {31'b0, o_inexact}, {31'b0, e.inexact});
        check({tag, "_overflow"}, {31'b0, o_overflow}, {31'b0, e.overflow});
        check({tag, "_latency"},  k, e.latency);
    endtask

    task automatic release_result();
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("ready_after_release", {31'b0, o_ready}, 32'd1);
        i_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        int unsigned seen;
        exp_t e;

        vecs[0]  = '{1'b0, 8'h80, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 8'h80, 27'h0800000, 32'h3E800000, 1'b0, 1'b0, 3};
        vecs[2]  = '{1'b0, 8'h7F, 27'h7FFFFFC, 32'h40000000, 1'b1, 1'b0, 0};
        vecs[3]  = '{1'b0, 8'hFE, 27'h7FFFFFC, 32'h7F800000, 1'b1, 1'b1, 0};
        vecs[4]  = '{1'b0, 8'h7F, 27'h4000004, 32'h3F800000, 1'b1, 1'b0, 0};
        vecs[5]  = '{1'b0, 8'h7F, 27'h400000C, 32'h3F800002, 1'b1, 1'b0, 0};
        vecs[6]  = '{1'b1, 8'h50, 27'h0000000, 32'h80000000, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b0, 8'hFF, 27'h012345F, 32'h7F82468B, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b0, 8'h03, 27'h0100000, 32'h00080000, 1'b0, 1'b0, 2};
        vecs[9]  = '{1'b0, 8'h01, 27'h3FFFFFC, 32'h00800000, 1'b1, 1'b0, 0};
        vecs[10] = '{1'b1, 8'h01, 27'h0000010, 32'h80000002, 1'b0, 1'b0, 0};
        vecs[11] = '{1'b0, 8'h90, 27'h4000006, 32'h48000001, 1'b1, 1'b0, 0};
        vecs[12] = '{1'b0, 8'h7F, 27'h0000100, 32'h36800000, 1'b0, 1'b0, 18};
        vecs[13] = '{1'b0, 8'h80, 27'h2000003, 32'h3F800001, 1'b1, 1'b0, 1};
        vecs[14] = '{1'b0, 8'hFE, 27'h4000000, 32'h7F000000, 1'b0, 1'b0, 0};

        #2;
        check("reset_ready",    {31'b0, o_ready}, 32'd1);
        check("reset_valid",    {31'b0, o_valid}, 32'd0);
        check("reset_result",   o_result, 32'd0);
        check("reset_flags",    {30'b0, o_inexact, o_overflow}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].sign, vecs[i].exp, vecs[i].mant);
            sb.push_back('{vecs[i].result, vecs[i].inexact, vecs[i].overflow, lat_of(vecs[i].nshift)});
            await_result(k);
            compare_output($sformatf("vec%0d", i), k);
            release_result();
        end

        // result must hold while downstream stalls, and DONE must ignore new operands
        send(1'b0, 8'h7F, 27'h400000C);
        e = '{32'h3F800002, 1'b1, 1'b0, lat_of(0)};
        sb.push_back(e);
        await_result(k);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_exp   = 8'h10;
            i_mant  = 27'h0000001;
            check("hold_result", o_result, e.result);
            check("hold_ready",  {31'b0, o_ready}, 32'd0);
            check("hold_valid",  {31'b0, o_valid}, 32'd1);
        end
        i_valid = 1'b0;
        compare_output("hold", k);
        release_result();
        check("idle_valid_low", {31'b0, o_valid}, 32'd0);

        // reset mid-shift discards the operand
        send(1'b0, 8'h7F, 27'h0000100);
        i_rst = 1'b1;
        #1;
        check("midrst_valid",  {31'b0, o_valid}, 32'd0);
        check("midrst_ready",  {31'b0, o_ready}, 32'd1);
        check("midrst_result", o_result, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
        check("midrst_no_result", seen, 32'd0);

        send(vecs[1].sign, vecs[1].exp, vecs[1].mant);
        sb.push_back('{vecs[1].result, vecs[1].inexact, vecs[1].overflow, lat_of(vecs[1].nshift)});
        await_result(k);
        compare_output("after_rst", k);
        release_result();

        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
